// File: rtl/lz4_win_feeder.sv
// rtl/lz4_win_feeder.sv - 32-bit word to sliding 4-byte window feeder for an LZ4 match engine
module lz4_win_feeder (
    input  logic        clk,
    input  logic        rstN,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    input  logic [2:0]  adv_bytes,
    output logic [31:0] win_data,
    output logic [2:0]  win_avail,
    output logic [2:0]  incr_bytes,
    output logic        done
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state, state_next;
    logic [63:0] buf_q, buf_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  remain;
    logic [2:0]  adv_eff;
    logic [2:0]  acc_bytes;
    logic        accept;
    logic [31:0] in_mask;
    logic [63:0] shifted;
    logic [63:0] incoming;

    always_comb begin
        win_avail  = (cnt > 4'd4) ? 3'd4 : cnt[2:0];
        adv_eff    = (adv_bytes > 3'd4) ? 3'd4 : adv_bytes;
        incr_bytes = (adv_eff < win_avail) ? adv_eff : win_avail;
        win_data   = buf_q[31:0];
        done       = (state == S_DONE);
        // Readiness is a function of registered state only, so it never waits on the consumer.
        in_ready   = rstN && (state == S_RUN) && (cnt <= 4'd4);
        accept     = in_valid && in_ready;
        acc_bytes  = !in_last ? 3'd4 : ((in_bytes > 3'd4) ? 3'd4 : in_bytes);
    end

    always_comb begin
        in_mask = 32'hFFFF_FFFF;
        case (acc_bytes)
            3'd0:    in_mask = 32'h0000_0000;
            3'd1:    in_mask = 32'h0000_00FF;
            3'd2:    in_mask = 32'h0000_FFFF;
            3'd3:    in_mask = 32'h00FF_FFFF;
            default: in_mask = 32'hFFFF_FFFF;
        endcase
    end

    // Retire first, then append behind the survivors; bytes beyond cnt stay zero.
    always_comb begin
        remain   = cnt - {1'b0, incr_bytes};
        shifted  = buf_q >> {incr_bytes, 3'b000};
        incoming = {32'h0, in_data & in_mask} << {remain[2:0], 3'b000};
        buf_next = accept ? (shifted | incoming) : shifted;
        cnt_next = remain + (accept ? {1'b0, acc_bytes} : 4'd0);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (accept && in_last)
                    state_next = (cnt_next == 4'd0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_next == 4'd0)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= S_RUN;
            cnt   <= 4'd0;
            buf_q <= 64'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            buf_q <= buf_next;
        end
    end

endmodule

// File: tb/tb_lz4_win_feeder.sv
// tb/tb_lz4_win_feeder.sv - scoreboard bench for lz4_win_feeder against a byte-queue model
module tb_lz4_win_feeder;

    logic        clk = 1'b0;
    logic        rstN;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic [2:0]  adv_bytes;
    logic [31:0] win_data;
    logic [2:0]  win_avail;
    logic [2:0]  incr_bytes;
    logic        done;

    lz4_win_feeder dut (
        .clk        (clk),
        .rstN       (rstN),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .adv_bytes  (adv_bytes),
        .win_data   (win_data),
        .win_avail  (win_avail),
        .incr_bytes (incr_bytes),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] win;
        logic [2:0]  avail;
        logic [2:0]  incr;
        logic        ready;
        logic        done;
        logic        rst;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] sbq[$];
    logic [7:0] mq[$];
    int         mode = 0;
    int         compared = 0;
    int         mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic [2:0] b, input logic [2:0] a, input logic r);
        exp_t e;
        int   avail, adv_e, incr, n;
        @(negedge clk);
        rstN      = !r;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        in_bytes  = b;
        adv_bytes = a;
        avail  = (mq.size() > 4) ? 4 : mq.size();
        adv_e  = (a > 4) ? 4 : int'(a);
        incr   = (adv_e < avail) ? adv_e : avail;
        e.win  = 32'h0;
        for (int i = 0; i < avail; i++) e.win[8*i +: 8] = mq[i];
        e.avail = 3'(avail);
        e.incr  = 3'(incr);
        e.ready = !r && (mode == 0) && (mq.size() <= 4);
        e.done  = (mode == 2);
        e.rst   = r;
        expq.push_back(e);
        if (r) begin
            mq.delete();
            sbq.delete();
            mode = 0;
        end else begin
            repeat (incr) void'(mq.pop_front());
            if (v && e.ready) begin
                n = l ? ((b > 4) ? 4 : int'(b)) : 4;
                for (int i = 0; i < n; i++) begin
                    mq.push_back(d[8*i +: 8]);
                    sbq.push_back(d[8*i +: 8]);
                end
            end
            if (mode == 2) mode = 0;
            else if (mode == 0 && v && e.ready && l) mode = (mq.size() == 0) ? 2 : 1;
            else if (mode == 1 && mq.size() == 0) mode = 2;
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] bt;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("win_data",   win_data,          e.win);
                chk("win_avail",  {29'h0, win_avail}, {29'h0, e.avail});
                chk("incr_bytes", {29'h0, incr_bytes}, {29'h0, e.incr});
                chk("in_ready",   {31'h0, in_ready},  {31'h0, e.ready});
                chk("done",       {31'h0, done},      {31'h0, e.done});
                if (!e.rst) begin
                    for (int i = 0; i < int'(e.incr); i++) begin
                        if (sbq.size() == 0) begin
                            chk("retire_underflow", 32'h1, 32'h0);
                        end else begin
                            bt = sbq.pop_front();
                            chk("retired_byte", {24'h0, win_data[8*i +: 8]}, {24'h0, bt});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
        in_bytes = 3'd0; adv_bytes = 3'd0;
        repeat (2) @(posedge clk);
        step(0, 32'h0, 0, 0, 0, 0);
        step(1, 32'h44332211, 0, 0, 0, 0);
        step(1, 32'h88776655, 0, 0, 3, 0);
        step(1, 32'hCAFEBABE, 0, 0, 0, 0);
        step(1, 32'hCAFEBABE, 0, 0, 1, 0);
        step(1, 32'hCAFEBABE, 0, 0, 0, 0);
        step(1, 32'h12345678, 0, 0, 3, 0);
        step(1, 32'h12345678, 0, 0, 4, 0);
        step(1, 32'h12345678, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 7, 0);
        step(0, 32'h0, 0, 0, 2, 0);
        step(0, 32'h0, 0, 0, 4, 0);
        step(1, 32'hDDCCBBAA, 1, 2, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 2, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(1, 32'hFFFFFFFF, 1, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(1, 32'h0A0B0C0D, 0, 0, 0, 0);
        step(1, 32'h99EE5511, 1, 6, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 99) == 0);
        end
        repeat (3) @(negedge clk);
        chk("expq_drained", expq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lz4_win_feeder.md
LZ4_WIN_FEEDER -- requirements
Module: lz4_win_feeder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rstN  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  upstream word valid.
REQ-004 SHALL have port in_ready  output  1  feeder can accept a word this cycle.
REQ-005 SHALL have port in_data  input  32  packed bytes; bits[7:0] = lowest address byte.
REQ-006 SHALL have port in_last  input  1  word is last of stream.
REQ-007 SHALL have port in_bytes  input  3  valid bytes in a last word, 0..4; ignored when in_last=0.
REQ-008 SHALL have port adv_bytes  input  3  consumer request to retire 0..4 window bytes this cycle.
REQ-009 SHALL have port win_data  output  32  current 4-byte window; bits[7:0] = oldest byte.
REQ-010 SHALL have port win_avail  output  3  valid bytes in win_data, 0..4.
REQ-011 SHALL have port incr_bytes  output  3  bytes actually retired this cycle; drives the absolute address counter.
REQ-012 SHALL have port done  output  1  one-cycle pulse: stream fully retired.

Function
REQ-013 SHALL hold an 8-byte buffer with byte count cnt, 0..8; window = buffer bytes 0..3, win_avail = min(cnt,4).
REQ-014 SHALL drive incr_bytes combinationally = min(adv_bytes, win_avail); adv_bytes 5..7 is treated as 4.
REQ-015 SHALL assert in_ready = 1 only when state is RUN, cnt <= 4 and rstN = 1; in_ready SHALL NOT depend on adv_bytes.
REQ-016 SHALL accept a word when in_valid & in_ready; the word holds 4 bytes if in_last=0, otherwise min(in_bytes,4) bytes.
REQ-017 SHALL, on the same edge, first shift out incr_bytes bytes, then append accepted bytes behind the remaining ones: cnt_next = cnt - incr_bytes + accepted.
REQ-018 SHALL make an accepted word visible in win_data/win_avail one cycle after acceptance; no combinational in_data-to-win_data path.
REQ-019 SHALL zero buffer bytes at positions >= cnt.
REQ-020 SHALL implement FSM RUN -> DRAIN on acceptance with in_last=1; DRAIN -> DONE when cnt_next = 0; DONE -> RUN unconditionally after one cycle.
REQ-021 SHALL take RUN -> DONE directly when a last word with 0 effective bytes is accepted and cnt_next = 0.
REQ-022 SHALL assert done only in state DONE; in_ready = 0 in DRAIN and DONE.
REQ-023 SHALL preserve byte order exactly: the concatenation of retired bytes equals the concatenation of accepted bytes.
REQ-024 SHALL ignore in_data upper bytes beyond in_bytes on a last word.

Reset
REQ-025 SHALL, when rstN = 0 at a rising edge, set state RUN, cnt 0, buffer 0; hence win_data 0, win_avail 0, incr_bytes 0, done 0.
REQ-026 SHALL force in_ready = 0 while rstN = 0; in_ready = 1 on the first cycle after release.
REQ-027 SHALL discard any partial stream when reset is asserted mid-operation; no done pulse for it.

Verification
REQ-028 SHALL pass: accept 0x44332211 (in_last=0), adv 0 -> next cycle win_data=0x44332211, win_avail=4, in_ready=1.
REQ-029 SHALL pass: cnt=4 window 0x44332211, adv_bytes=3 and accept 0x88776655 same cycle -> next win_data=0x77665544, cnt=5, incr_bytes was 3.
REQ-030 SHALL pass: cnt=2 (bytes 0x11,0x22), adv_bytes=4 -> incr_bytes=2, next cnt=0, win_data=0, win_avail=0.
REQ-031 SHALL pass: last word 0xDDCCBBAA, in_bytes=2, adv 0 -> win_data=0x0000BBAA, win_avail=2, state DRAIN, in_ready=0; then adv 2 -> done=1 next cycle, then in_ready=1.
REQ-032 SHALL pass: cnt=8, in_valid=1 held -> in_ready=0, no acceptance until adv retires >= 4 bytes; no byte lost or duplicated.
REQ-033 SHALL pass: rstN=0 for one cycle while cnt=6 in DRAIN -> next cycle win_avail=0, done=0, in_ready=1.
